tft_rx_timing: RTL and testbench

TFT_RX_TIMING -- requirements
Module: tft_rx_timing

---
 rtl/tft_rx_timing.sv | 186 ++++++++++++++++++
 tb/tb_tft_rx_timing.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tft_rx_timing.sv
`timescale 1ns/1ps
// TFT receive timing recovery: measures line/frame geometry from de/hs/vs,
// locks once two consecutive frames agree, and forwards pixels with x/y.
module tft_rx_timing #(
   parameter int DATA_W = 16
) (
   input  logic              clk_33M,
   input  logic              rst_n,
   input  logic              TFT_de,
   input  logic              TFT_hs,
   input  logic              TFT_vs,
   input  logic [DATA_W-1:0] TFT_rgb,
   output logic              pix_valid,
   output logic [DATA_W-1:0] pix_data,
   output logic [11:0]       pix_x,
   output logic [11:0]       pix_y,
   output logic              frame_start,
   output logic [11:0]       h_total,
   output logic [11:0]       h_active,
   output logic [11:0]       v_total,
   output logic [11:0]       v_active,
   output logic              locked,
   output logic              timing_err
);

   localparam int CW = 12;
   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CMAX) ? v : v + ONE;
   endfunction

   state_t              state;
   logic                vld_p0, hs_p0, vs_p0;
   logic [DATA_W-1:0]   rgb_p0;
   logic                vld_p1, hs_p1, vs_p1;
   logic [CW-1:0]       hcnt, decnt, lcnt, acnt, y_cnt;
   logic [CW-1:0]       line_len, line_act;
   logic                line_de;

   logic                hs_edge, vs_edge, de_rise, de_fall;
   logic                line_de_c, first_de;
   logic [CW-1:0]       cur_ht, cur_ha, cur_vt, cur_va;
   logic                cap_match, cap_nz;

   assign hs_edge   = !hs_p0 && hs_p1;
   assign vs_edge   = !vs_p0 && vs_p1;
   assign de_rise   = vld_p0 && !vld_p1;
   assign de_fall   = !vld_p0 && vld_p1;
   // A pixel coinciding with an hs edge belongs to the new line.
   assign line_de_c = hs_edge ? 1'b0 : line_de;
   assign first_de  = vld_p0 && !line_de_c;

   // Captures see the line that ends in this very cycle, if any.
   assign cur_ht    = hs_edge ? sat_inc(hcnt) : line_len;
   assign cur_ha    = de_fall ? decnt : line_act;
   assign cur_vt    = lcnt;
   assign cur_va    = acnt;
   assign cap_match = (cur_ht == h_total) && (cur_ha == h_active) &&
                      (cur_vt == v_total) && (cur_va == v_active);
   assign cap_nz    = (cur_ha != '0) && (cur_va != '0);

   // Stage p0: input registers; stage p1: delayed copies for edge detection
   always_ff @(posedge clk_33M or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         hs_p0  <= 1'b1;
         vs_p0  <= 1'b1;
         rgb_p0 <= '0;
         vld_p1 <= 1'b0;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
      end else begin
         vld_p0 <= TFT_de;
         hs_p0  <= TFT_hs;
         vs_p0  <= TFT_vs;
         rgb_p0 <= TFT_rgb;
         vld_p1 <= vld_p0;
         hs_p1  <= hs_p0;
         vs_p1  <= vs_p0;
      end
   end

   // Timing measurement counters, all saturating
   always_ff @(posedge clk_33M or negedge rst_n) begin
      if (!rst_n) begin
         hcnt     <= '0;
         decnt    <= '0;
         lcnt     <= '0;
         acnt     <= '0;
         y_cnt    <= '0;
         line_len <= '0;
         line_act <= '0;
         line_de  <= 1'b0;
      end else begin
         if (hs_edge) begin
            line_len <= sat_inc(hcnt);
            hcnt     <= '0;
            decnt    <= {{(CW-1){1'b0}}, vld_p0};
         end else begin
            hcnt <= sat_inc(hcnt);
            if (vld_p0) decnt <= sat_inc(decnt);
         end
         if (de_fall) line_act <= decnt;
         line_de <= line_de_c | vld_p0;

         if (vs_edge) begin
            lcnt <= hs_edge ? ONE : '0;
            acnt <= first_de ? ONE : '0;
         end else begin
            if (hs_edge)  lcnt <= sat_inc(lcnt);
            if (first_de) acnt <= sat_inc(acnt);
         end

         if (vs_edge)      y_cnt <= '0;
         else if (de_fall) y_cnt <= sat_inc(y_cnt);
      end
   end

   // Stage p2: pixel outputs and the lock FSM
   always_ff @(posedge clk_33M or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SEARCH;
         pix_valid   <= 1'b0;
         pix_data    <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         h_total     <= '0;
         h_active    <= '0;
         v_total     <= '0;
         v_active    <= '0;
         locked      <= 1'b0;
         timing_err  <= 1'b0;
      end else begin
         pix_data  <= rgb_p0;
         pix_valid <= vld_p0 && ((state != SEARCH) || vs_edge);
         pix_y     <= vs_edge ? '0 : y_cnt;
         if (de_rise || hs_edge) pix_x <= '0;
         else if (vld_p0)        pix_x <= sat_inc(pix_x);

         frame_start <= 1'b0;
         timing_err  <= 1'b0;
         case (state)
            SEARCH: begin
               if (vs_edge) state <= MEASURE;
            end
            MEASURE: begin
               if (vs_edge) begin
                  frame_start <= 1'b1;
                  h_total     <= cur_ht;
                  h_active    <= cur_ha;
                  v_total     <= cur_vt;
                  v_active    <= cur_va;
                  if (cap_match && cap_nz) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (vs_edge) begin
                  frame_start <= 1'b1;
                  if (!cap_match) begin
                     timing_err <= 1'b1;
                     h_total    <= cur_ht;
                     h_active   <= cur_ha;
                     v_total    <= cur_vt;
                     v_active   <= cur_va;
                     state      <= MEASURE;
                     locked     <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tft_rx_timing.sv
`timescale 1ns/1ps
// Bench for tft_rx_timing: scaled-down panel timing (40 clocks x 12 lines),
// per-cycle expected pixel stream in a queue, directed lock/relock/reset steps.
module tb_tft_rx_timing;

   localparam int HT = 40, HS_W = 2, DE_OFS = 8;
   localparam int VT = 12, VS_L = 2, VA_OFS = 4;

   logic        clk_33M = 1'b0;
   logic        rst_n;
   logic        TFT_de, TFT_hs, TFT_vs;
   logic [15:0] TFT_rgb;
   logic        pix_valid, frame_start, locked, timing_err;
   logic [15:0] pix_data;
   logic [11:0] pix_x, pix_y, h_total, h_active, v_total, v_active;

   always #5 clk_33M = ~clk_33M;

   tft_rx_timing dut (
      .clk_33M(clk_33M), .rst_n(rst_n), .TFT_de(TFT_de), .TFT_hs(TFT_hs),
      .TFT_vs(TFT_vs), .TFT_rgb(TFT_rgb), .pix_valid(pix_valid),
      .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .h_total(h_total), .h_active(h_active),
      .v_total(v_total), .v_active(v_active), .locked(locked),
      .timing_err(timing_err)
   );

   typedef struct packed {
      logic        v;
      logic [15:0] d;
      logic [11:0] x;
      logic [11:0] y;
   } pix_t;

   pix_t sbq[$];
   int   total = 0, bad = 0;
   int   fs_cnt = 0, te_cnt = 0, lk_cnt = 0;
   int   fs_base, lk_base;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_pix_valid"}, {31'd0, pix_valid}, 0);
      chk({p, "_pix_data"}, {16'd0, pix_data}, 0);
      chk({p, "_pix_x"}, {20'd0, pix_x}, 0);
      chk({p, "_pix_y"}, {20'd0, pix_y}, 0);
      chk({p, "_frame_start"}, {31'd0, frame_start}, 0);
      chk({p, "_h_total"}, {20'd0, h_total}, 0);
      chk({p, "_h_active"}, {20'd0, h_active}, 0);
      chk({p, "_v_total"}, {20'd0, v_total}, 0);
      chk({p, "_v_active"}, {20'd0, v_active}, 0);
      chk({p, "_locked"}, {31'd0, locked}, 0);
      chk({p, "_timing_err"}, {31'd0, timing_err}, 0);
   endtask

   task automatic chk_timing(input string p, input int ht, input int ha, input int vt, input int va);
      chk({p, "_h_total"}, {20'd0, h_total}, ht);
      chk({p, "_h_active"}, {20'd0, h_active}, ha);
      chk({p, "_v_total"}, {20'd0, v_total}, vt);
      chk({p, "_v_active"}, {20'd0, v_active}, va);
   endtask

   // Output stage lags inputs by two clocks: an entry is due once a newer one exists.
   always @(posedge clk_33M) begin
      pix_t e;
      #1;
      if (frame_start === 1'b1) fs_cnt++;
      if (timing_err === 1'b1) te_cnt++;
      if (locked === 1'b1) lk_cnt++;
      if (sbq.size() >= 2) begin
         e = sbq.pop_front();
         chk("pix_valid", {31'd0, pix_valid}, {31'd0, e.v});
         if (e.v) begin
            chk("pix_data", {16'd0, pix_data}, {16'd0, e.d});
            chk("pix_x", {20'd0, pix_x}, {20'd0, e.x});
            chk("pix_y", {20'd0, pix_y}, {20'd0, e.y});
         end
      end
   end

   task automatic drive_raw(input logic hs, input logic vs, input logic de,
                            input logic pv, input int x, input int y);
      pix_t e;
      @(negedge clk_33M);
      TFT_hs  = hs;
      TFT_vs  = vs;
      TFT_de  = de;
      TFT_rgb = 16'($urandom);
      e.v = de && pv;
      e.d = TFT_rgb;
      e.x = 12'(x);
      e.y = 12'(y);
      sbq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_raw(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic drive_cycle(input int l, input int c, input int de_w,
                              input logic de0, input logic pv);
      logic act, early;
      int   x, y;
      act   = (l >= VA_OFS) && (c >= DE_OFS) && (c < DE_OFS + de_w);
      early = de0 && (l == 0) && (c < 4);
      x     = early ? c : c - DE_OFS;
      y     = early ? 0 : l - VA_OFS + (de0 ? 1 : 0);
      drive_raw(c >= HS_W, l >= VS_L, act || early, pv, x, y);
   endtask

   task automatic frame(input int de_w, input logic de0);
      for (int l = 0; l < VT; l++)
         for (int c = 0; c < HT; c++) drive_cycle(l, c, de_w, de0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; TFT_de = 1'b0; TFT_hs = 1'b1; TFT_vs = 1'b1; TFT_rgb = '0;
      idle(3);
      #1 chk_zero("rst0");
      rst_n = 1'b1;
      idle(5);

      // Lock acquisition over three nominal frames
      frame(24, 1'b0);
      chk("f1_locked", {31'd0, locked}, 0);
      chk("f1_h_total", {20'd0, h_total}, 0);
      chk("f1_fs_cnt", fs_cnt, 0);
      frame(24, 1'b0);
      chk_timing("f2", 40, 24, 12, 8);
      chk("f2_locked", {31'd0, locked}, 0);
      chk("f2_fs_cnt", fs_cnt, 1);
      frame(24, 1'b0);
      chk("f3_locked", {31'd0, locked}, 1);
      chk("f3_fs_cnt", fs_cnt, 2);

      // Active width change while locked, then relock
      frame(16, 1'b0);
      chk("f4_locked", {31'd0, locked}, 1);
      chk("f4_h_active", {20'd0, h_active}, 24);
      chk("f4_te_cnt", te_cnt, 0);
      frame(16, 1'b0);
      chk_timing("f5", 40, 16, 12, 8);
      chk("f5_locked", {31'd0, locked}, 0);
      chk("f5_te_cnt", te_cnt, 1);
      frame(16, 1'b0);
      chk("f6_locked", {31'd0, locked}, 1);
      chk("f6_te_cnt", te_cnt, 1);
      chk("f6_fs_cnt", fs_cnt, 5);

      // Reset in the middle of an active line
      for (int l = 0; l < 6; l++)
         for (int c = 0; c < HT; c++) drive_cycle(l, c, 16, 1'b0, 1'b1);
      for (int c = 0; c < 20; c++) drive_cycle(6, c, 16, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      sbq.delete();
      #1 chk_zero("rst_mid");
      for (int c = 20; c < HT; c++) begin
         drive_cycle(6, c, 16, 1'b0, 1'b0);
         if (c == 22) rst_n = 1'b1;
      end
      for (int l = 7; l < VT; l++)
         for (int c = 0; c < HT; c++) drive_cycle(l, c, 16, 1'b0, 1'b0);
      chk("rst_mid_locked_after", {31'd0, locked}, 0);
      chk("rst_mid_h_total_after", {20'd0, h_total}, 0);

      // de rises in the same cycle as the first vs edge after reset
      frame(24, 1'b1);
      chk("de0_locked", {31'd0, locked}, 0);
      idle(3);

      // Long run with hs/vs held high: saturation, no frame_start, no lock
      #2 rst_n = 1'b0;
      sbq.delete();
      idle(2);
      rst_n = 1'b1;
      idle(3);
      fs_base = fs_cnt;
      lk_base = lk_cnt;
      drive_raw(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      drive_raw(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 4200; i++)
         drive_raw(1'b1, 1'b1, 1'b1, 1'b1, (i > 4095) ? 4095 : i, 0);
      for (int j = 0; j < 800; j++)
         drive_raw(1'b1, 1'b1, logic'(j % 2), 1'b1, 0, j / 2 + 1);
      chk("sat_fs_none", fs_cnt, fs_base);
      chk("sat_lk_none", lk_cnt, lk_base);
      drive_raw(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      drive_raw(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(4);
      chk_timing("sat", 4095, 4095, 1, 1);
      chk("sat_locked", {31'd0, locked}, 0);
      chk("sat_fs_after", fs_cnt, fs_base + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
